// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and a one-cycle load-use interlock.
// Drives the ALU operand and opcode inputs combinationally from the registered EX state.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [5:0]      id_aluc,
  input  logic            id_src_imm,
  input  logic            id_src_pc,
  input  logic            id_reg_we,
  input  logic            id_mem_re,
  input  logic            id_mem_we,
  input  logic            flush,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_reg_we,
  input  logic [XLEN-1:0] mem_result,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_reg_we,
  input  logic [XLEN-1:0] wb_result,
  output logic            stall,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [5:0]      alu_aluc,
  output logic            ex_valid,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_we,
  output logic            ex_mem_re,
  output logic            ex_mem_we,
  output logic [XLEN-1:0] ex_store_data
);

  localparam logic [5:0] ALUC_ADD = 6'b000000;

  logic            vld_p0;
  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] rs1_data_p0;
  logic [XLEN-1:0] rs2_data_p0;
  logic [XLEN-1:0] imm_p0;
  logic [REGW-1:0] rs1_p0;
  logic [REGW-1:0] rs2_p0;
  logic [REGW-1:0] rd_p0;
  logic [5:0]      aluc_p0;
  logic            src_imm_p0;
  logic            src_pc_p0;
  logic            reg_we_p0;
  logic            mem_re_p0;
  logic            mem_we_p0;

  logic            hit_rs1;
  logic            hit_rs2;
  logic            squash;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // MEM is the younger producer, so it wins over WB; x0 is never a forwarding target.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REGW-1:0] src,
    input logic [XLEN-1:0] reg_val,
    input logic [REGW-1:0] m_rd,
    input logic            m_we,
    input logic [XLEN-1:0] m_val,
    input logic [REGW-1:0] w_rd,
    input logic            w_we,
    input logic [XLEN-1:0] w_val
  );
    logic [XLEN-1:0] sel;
    sel = reg_val;
    if (m_we && (m_rd != '0) && (m_rd == src)) begin
      sel = m_val;
    end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
      sel = w_val;
    end
    return sel;
  endfunction

  // A load in EX cannot supply its data until after MEM, so a dependent ID op waits one cycle.
  always_comb begin
    hit_rs1 = id_use_rs1 && (id_rs1 == rd_p0);
    hit_rs2 = id_use_rs2 && (id_rs2 == rd_p0);
    stall   = id_valid && vld_p0 && mem_re_p0 && (rd_p0 != '0) && (hit_rs1 || hit_rs2);
  end

  assign squash = rst || flush || stall;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (squash) begin
      vld_p0      <= 1'b0;
      pc_p0       <= '0;
      rs1_data_p0 <= '0;
      rs2_data_p0 <= '0;
      imm_p0      <= '0;
      rs1_p0      <= '0;
      rs2_p0      <= '0;
      rd_p0       <= '0;
      aluc_p0     <= ALUC_ADD;
      src_imm_p0  <= 1'b0;
      src_pc_p0   <= 1'b0;
      reg_we_p0   <= 1'b0;
      mem_re_p0   <= 1'b0;
      mem_we_p0   <= 1'b0;
    end else begin
      vld_p0      <= id_valid;
      pc_p0       <= id_pc;
      rs1_data_p0 <= id_rs1_data;
      rs2_data_p0 <= id_rs2_data;
      imm_p0      <= id_imm;
      rs1_p0      <= id_rs1;
      rs2_p0      <= id_rs2;
      rd_p0       <= id_rd;
      aluc_p0     <= id_aluc;
      src_imm_p0  <= id_src_imm;
      src_pc_p0   <= id_src_pc;
      reg_we_p0   <= id_reg_we;
      mem_re_p0   <= id_mem_re;
      mem_we_p0   <= id_mem_we;
    end
  end

  always_comb begin
    fwd_rs1 = fwd_sel(rs1_p0, rs1_data_p0, mem_rd, mem_reg_we, mem_result,
                      wb_rd, wb_reg_we, wb_result);
    fwd_rs2 = fwd_sel(rs2_p0, rs2_data_p0, mem_rd, mem_reg_we, mem_result,
                      wb_rd, wb_reg_we, wb_result);
  end

  assign alu_a         = src_pc_p0  ? pc_p0  : fwd_rs1;
  assign alu_b         = src_imm_p0 ? imm_p0 : fwd_rs2;
  assign alu_aluc      = aluc_p0;
  assign ex_store_data = fwd_rs2;
  assign ex_valid      = vld_p0;
  assign ex_rd         = rd_p0;
  assign ex_reg_we     = reg_we_p0;
  assign ex_mem_re     = mem_re_p0;
  assign ex_mem_we     = mem_we_p0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of ID/forwarding vectors with a scoreboard of expected EX outputs,
// plus hand sequences for reset and reset during a load-use stall.
module tb_id_ex_stage;

  localparam int unsigned ADD = 0, SUB = 8, AND = 2, OR = 10, XOR = 4;
  localparam int unsigned LUI = 12, SLL = 5, SRL = 13, SRA = 29;

  typedef struct {
    int unsigned v, pc, rs1d, rs2d, imm, rs1, rs2, u1, u2, rd, aluc, si, sp, we, re, mwe, fl;
  } id_t;
  typedef struct {
    int unsigned mrd, mwe, mres, wrd, wwe, wres;
  } fw_t;
  typedef struct {
    int unsigned stall, vld, a, b, aluc, rd, we, re, mwe, store;
  } exp_t;
  typedef struct {
    id_t  id;
    fw_t  fw;
    exp_t ex;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_src_imm, id_src_pc;
  logic        id_reg_we, id_mem_re, id_mem_we, flush, mem_reg_we, wb_reg_we;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, mem_result, wb_result;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [5:0]  id_aluc;
  logic        stall, ex_valid, ex_reg_we, ex_mem_re, ex_mem_we;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [5:0]  alu_aluc;
  logic [4:0]  ex_rd;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t tab[21];

  id_ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_aluc(id_aluc), .id_src_imm(id_src_imm), .id_src_pc(id_src_pc),
    .id_reg_we(id_reg_we), .id_mem_re(id_mem_re), .id_mem_we(id_mem_we), .flush(flush),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_result(wb_result),
    .stall(stall), .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re),
    .ex_mem_we(ex_mem_we), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, req);
    end
  endtask

  task automatic drive(input id_t d, input fw_t f);
    id_valid    = d.v[0];   id_pc       = d.pc;     id_rs1_data = d.rs1d;
    id_rs2_data = d.rs2d;   id_imm      = d.imm;    id_rs1      = d.rs1[4:0];
    id_rs2      = d.rs2[4:0]; id_use_rs1 = d.u1[0]; id_use_rs2  = d.u2[0];
    id_rd       = d.rd[4:0]; id_aluc    = d.aluc[5:0]; id_src_imm = d.si[0];
    id_src_pc   = d.sp[0];  id_reg_we   = d.we[0];  id_mem_re   = d.re[0];
    id_mem_we   = d.mwe[0]; flush       = d.fl[0];
    mem_rd      = f.mrd[4:0]; mem_reg_we = f.mwe[0]; mem_result = f.mres;
    wb_rd       = f.wrd[4:0]; wb_reg_we  = f.wwe[0]; wb_result  = f.wres;
  endtask

  task automatic apply(input int idx, input vec_t t);
    exp_t e;
    @(negedge clk);
    drive(t.id, t.fw);
    #1;
    chk($sformatf("v%0d stall", idx), 32'(stall), t.ex.stall);
    sb.push_back(t.ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL v%0d scoreboard: got empty queue required one entry", idx);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d ex_valid", idx), 32'(ex_valid), e.vld);
      chk($sformatf("v%0d alu_a", idx), alu_a, e.a);
      chk($sformatf("v%0d alu_b", idx), alu_b, e.b);
      chk($sformatf("v%0d alu_aluc", idx), 32'(alu_aluc), e.aluc);
      chk($sformatf("v%0d ex_rd", idx), 32'(ex_rd), e.rd);
      chk($sformatf("v%0d ex_reg_we", idx), 32'(ex_reg_we), e.we);
      chk($sformatf("v%0d ex_mem_re", idx), 32'(ex_mem_re), e.re);
      chk($sformatf("v%0d ex_mem_we", idx), 32'(ex_mem_we), e.mwe);
      chk($sformatf("v%0d ex_store_data", idx), ex_store_data, e.store);
    end
  endtask

  initial begin
    id_t idz;
    fw_t fz;
    vec_t lw5, add6;

    //        v pc     rs1d     rs2d   imm          rs1 rs2 u1 u2 rd aluc si sp we re mwe fl
    tab[0]  = '{'{1,'h100, 10,     5,     0,          1, 2, 1,1, 3, ADD, 0,0,1,0,0,0},
                '{0,0,0,0,0,0},         '{0,1,10,5,ADD,3,1,0,0,5}};
    tab[1]  = '{'{1,'h104,'h10,   5,     0,          1, 2, 1,1, 3, SUB, 0,0,1,0,0,0},
                '{1,1,'h20,1,1,'h99},   '{0,1,'h20,5,SUB,3,1,0,0,5}};
    tab[2]  = '{'{1,'h108, 7,     8,     0,          1, 2, 1,1, 4, AND, 0,0,1,0,0,0},
                '{1,1,'h11,2,1,'h22},   '{0,1,'h11,'h22,AND,4,1,0,0,'h22}};
    tab[3]  = '{'{1,'h10c, 1,     2,     0,          3, 3, 1,1, 5, OR,  0,0,1,0,0,0},
                '{3,1,'h33,3,1,'h44},   '{0,1,'h33,'h33,OR,5,1,0,0,'h33}};
    tab[4]  = '{'{1,'h110,'h60,  'h70,  0,          6, 7, 1,1, 6, XOR, 0,0,1,0,0,0},
                '{6,0,'hAA,7,0,'hBB},   '{0,1,'h60,'h70,XOR,6,1,0,0,'h70}};
    tab[5]  = '{'{1,'h114, 0,     0,     0,          0, 0, 1,1, 8, ADD, 0,0,1,0,0,0},
                '{0,1,'hDEAD,0,1,'hBEEF}, '{0,1,0,0,ADD,8,1,0,0,0}};
    tab[6]  = '{'{1,'h118,'h1000, 0,     4,          1, 0, 1,0, 5, ADD, 1,0,1,1,0,0},
                '{0,0,0,0,0,0},         '{0,1,'h1000,4,ADD,5,1,1,0,0}};
    tab[7]  = '{'{1,'h11c, 0,     10,    0,          5, 1, 1,1, 6, ADD, 0,0,1,0,0,0},
                '{0,0,0,0,0,0},         '{1,0,0,0,ADD,0,0,0,0,0}};
    tab[8]  = '{'{1,'h11c, 0,     10,    0,          5, 1, 1,1, 6, ADD, 0,0,1,0,0,0},
                '{0,0,0,5,1,'h1234},    '{0,1,'h1234,10,ADD,6,1,0,0,10}};
    tab[9]  = '{'{1,'h120,'h2000, 0,     8,          1, 0, 1,0, 7, ADD, 1,0,1,1,0,0},
                '{0,0,0,0,0,0},         '{0,1,'h2000,8,ADD,7,1,1,0,0}};
    tab[10] = '{'{1,'h124, 3,     4,     0,          7, 2, 1,1, 9, ADD, 0,0,1,0,0,1},
                '{0,0,0,0,0,0},         '{1,0,0,0,ADD,0,0,0,0,0}};
    tab[11] = '{'{1,'h128, 0,     0,    'h12345000,  0, 0, 0,0,10, LUI, 1,0,1,0,0,0},
                '{0,0,0,0,0,0},         '{0,1,0,'h12345000,LUI,10,1,0,0,0}};
    tab[12] = '{'{1,'h12c,'h77,  'h88,  0,          1, 2, 1,1,11, SLL, 0,0,1,0,0,1},
                '{0,0,0,0,0,0},         '{0,0,0,0,ADD,0,0,0,0,0}};
    tab[13] = '{'{1,'h200,'h99,  'h55, 'h1000,      1, 2, 1,1,11, SRA, 1,1,1,0,0,0},
                '{0,0,0,0,0,0},         '{0,1,'h200,'h1000,SRA,11,1,0,0,'h55}};
    tab[14] = '{'{1,'h204,'h3000, 0,     0,          1, 0, 1,0,12, ADD, 1,0,1,1,0,0},
                '{0,0,0,0,0,0},         '{0,1,'h3000,0,ADD,12,1,1,0,0}};
    tab[15] = '{'{1,'h208, 3,    'hC,   'h10,       3,12, 1,1, 0, ADD, 1,0,0,0,1,0},
                '{0,0,0,0,0,0},         '{1,0,0,0,ADD,0,0,0,0,0}};
    tab[16] = '{'{1,'h208, 3,    'hC,   'h10,       3,12, 1,1, 0, ADD, 1,0,0,0,1,0},
                '{0,0,0,12,1,'h5678},   '{0,1,3,'h10,ADD,0,0,0,1,'h5678}};
    tab[17] = '{'{1,'h20c,'h4000, 0,     0,          1, 0, 1,0,13, ADD, 1,0,1,1,0,0},
                '{0,0,0,0,0,0},         '{0,1,'h4000,0,ADD,13,1,1,0,0}};
    tab[18] = '{'{1,'h210, 5,     6,     0,         13,13, 0,0,14, SRL, 0,0,1,0,0,0},
                '{0,0,0,0,0,0},         '{0,1,5,6,SRL,14,1,0,0,6}};
    tab[19] = '{'{1,'h214,'h100,  0,     0,          1, 0, 1,0,15, ADD, 1,0,1,1,0,0},
                '{0,0,0,0,0,0},         '{0,1,'h100,0,ADD,15,1,1,0,0}};
    tab[20] = '{'{0,'h218, 7,     0,     0,         15, 0, 1,0, 0, ADD, 0,0,0,0,0,0},
                '{0,0,0,0,0,0},         '{0,0,7,0,ADD,0,0,0,0,0}};

    idz = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    fz  = '{0,0,0,0,0,0};
    drive(idz, fz);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ex_valid", 32'(ex_valid), 0);
    chk("reset alu_aluc", 32'(alu_aluc), ADD);
    chk("reset stall", 32'(stall), 0);
    chk("reset ex_rd", 32'(ex_rd), 0);
    chk("reset ex_reg_we", 32'(ex_reg_we), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) apply(i, tab[i]);

    // Reset arriving while a load-use stall is being raised.
    lw5  = tab[6];
    add6 = tab[7];
    @(negedge clk);
    drive(lw5.id, fz);
    @(posedge clk);
    #1;
    chk("rs lw in EX", 32'(ex_mem_re), 1);
    @(negedge clk);
    drive(add6.id, fz);
    #1;
    chk("rs stall before reset", 32'(stall), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rs ex_valid", 32'(ex_valid), 0);
    chk("rs ex_mem_re", 32'(ex_mem_re), 0);
    chk("rs stall cleared", 32'(stall), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rs add enters ex_valid", 32'(ex_valid), 1);
    chk("rs add enters ex_rd", 32'(ex_rd), 6);
    chk("rs add alu_b", alu_b, 10);

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard drain: got %0d leftover entries required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
